// File: rtl/cpu_mem_arbiter_if.sv
// Bus bundle for cpu_mem_arbiter: instruction master, data master and the
// shared memory port. The arbiter connects through the slave modport; the
// environment (CPU masters plus memory model) uses the master modport.
interface cpu_mem_arbiter_if;
  // instruction master
  logic        inst_cyc_in;
  logic        inst_stb_in;
  logic [31:0] inst_addr_in;
  logic        inst_akn_out;
  logic        inst_stall_out;
  logic        inst_err_out;
  logic [31:0] inst_data_out;
  // data master
  logic        data_cyc_in;
  logic        data_stb_in;
  logic        data_we_in;
  logic [3:0]  data_be_in;
  logic [31:0] data_addr_in;
  logic [31:0] data_wdata_in;
  logic        data_akn_out;
  logic        data_stall_out;
  logic        data_err_out;
  logic [31:0] data_rdata_out;
  // shared memory port
  logic        mem_cyc_out;
  logic        mem_stb_out;
  logic        mem_we_out;
  logic [3:0]  mem_be_out;
  logic [31:0] mem_addr_out;
  logic [31:0] mem_wdata_out;
  logic        mem_akn_in;
  logic        mem_stall_in;
  logic [31:0] mem_rdata_in;

  modport slave (
    input  inst_cyc_in, inst_stb_in, inst_addr_in,
    output inst_akn_out, inst_stall_out, inst_err_out, inst_data_out,
    input  data_cyc_in, data_stb_in, data_we_in, data_be_in, data_addr_in, data_wdata_in,
    output data_akn_out, data_stall_out, data_err_out, data_rdata_out,
    output mem_cyc_out, mem_stb_out, mem_we_out, mem_be_out, mem_addr_out, mem_wdata_out,
    input  mem_akn_in, mem_stall_in, mem_rdata_in
  );

  modport master (
    output inst_cyc_in, inst_stb_in, inst_addr_in,
    input  inst_akn_out, inst_stall_out, inst_err_out, inst_data_out,
    output data_cyc_in, data_stb_in, data_we_in, data_be_in, data_addr_in, data_wdata_in,
    input  data_akn_out, data_stall_out, data_err_out, data_rdata_out,
    input  mem_cyc_out, mem_stb_out, mem_we_out, mem_be_out, mem_addr_out, mem_wdata_out,
    output mem_akn_in, mem_stall_in, mem_rdata_in
  );
endinterface

// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter: shares one pipelined memory port between an instruction
// fetch master and a data master. Up to 3 requests may be outstanding; a
// watchdog aborts the grant when no acknowledge arrives for TIMEOUT_CYC
// cycles. Define ARB_RR_EN for round-robin on simultaneous requests;
// otherwise the data master has fixed priority.
module cpu_mem_arbiter #(
  parameter int TIMEOUT_CYC = 255  // legal range 2..255
) (
  input logic             sys_clk,
  input logic             sys_rst,   // asynchronous, active low
  cpu_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, ABORT} state_t;

  localparam logic [7:0] TIMEOUT_V = 8'(TIMEOUT_CYC);

  state_t     r_state, w_state_nxt;
  logic [1:0] r_outst, w_outst_nxt;
  logic [7:0] r_wdog,  w_wdog_nxt;
  // Owner of the current grant (1 = data). The error pulse in ABORT needs it;
  // with ARB_RR_EN it doubles as the last-grant record.
  logic       r_owner_d, w_owner_d_nxt;

  logic w_gnt, w_own_d, w_own_cyc, w_own_stb, w_full, w_mem_stb, w_accept;

  assign w_gnt     = (r_state == GNT_I) || (r_state == GNT_D);
  assign w_own_d   = (r_state == GNT_D);
  assign w_own_cyc = w_own_d ? bus.data_cyc_in : bus.inst_cyc_in;
  assign w_own_stb = w_own_d ? bus.data_stb_in : bus.inst_stb_in;
  assign w_full    = (r_outst == 2'd3);
  // A dropped cyc or a full pipeline blocks the strobe toward memory.
  assign w_mem_stb = w_gnt & w_own_cyc & w_own_stb & ~w_full;
  assign w_accept  = w_mem_stb & ~bus.mem_stall_in;

  // Bus outputs: idle values by default, owner routing while granted.
  always_comb begin
    // NOTE: every output gets a value before the case so no path infers a latch.
    bus.inst_akn_out   = 1'b0;
    bus.inst_stall_out = 1'b1;
    bus.inst_err_out   = 1'b0;
    bus.inst_data_out  = '0;
    bus.data_akn_out   = 1'b0;
    bus.data_stall_out = 1'b1;
    bus.data_err_out   = 1'b0;
    bus.data_rdata_out = '0;
    bus.mem_cyc_out    = 1'b0;
    bus.mem_stb_out    = 1'b0;
    bus.mem_we_out     = 1'b0;
    bus.mem_be_out     = '0;
    bus.mem_addr_out   = '0;
    bus.mem_wdata_out  = '0;
    case (r_state)
      GNT_I: begin
        bus.mem_cyc_out    = bus.inst_cyc_in;
        bus.mem_stb_out    = w_mem_stb;
        bus.mem_be_out     = 4'hF;
        bus.mem_addr_out   = bus.inst_addr_in;
        bus.inst_stall_out = bus.mem_stall_in | w_full;
        bus.inst_akn_out   = bus.mem_akn_in;
        bus.inst_data_out  = bus.mem_rdata_in;
      end
      GNT_D: begin
        bus.mem_cyc_out    = bus.data_cyc_in;
        bus.mem_stb_out    = w_mem_stb;
        bus.mem_we_out     = bus.data_we_in;
        bus.mem_be_out     = bus.data_be_in;
        bus.mem_addr_out   = bus.data_addr_in;
        bus.mem_wdata_out  = bus.data_wdata_in;
        bus.data_stall_out = bus.mem_stall_in | w_full;
        bus.data_akn_out   = bus.mem_akn_in;
        bus.data_rdata_out = bus.mem_rdata_in;
      end
      ABORT: begin
        // Any akn arriving now is dropped: akn outputs stay at their defaults.
        if (r_owner_d) bus.data_err_out = 1'b1;
        else           bus.inst_err_out = 1'b1;
      end
      default: ;  // IDLE keeps the defaults
    endcase
  end

  // Next state: arbitration in IDLE, outstanding/watchdog tracking in a grant.
  always_comb begin
    w_state_nxt   = r_state;
    w_owner_d_nxt = r_owner_d;
    w_outst_nxt   = r_outst;
    w_wdog_nxt    = r_wdog;
    case (r_state)
      IDLE: begin
        w_outst_nxt = '0;
        w_wdog_nxt  = '0;
        if (bus.inst_cyc_in && bus.data_cyc_in) begin
`ifdef ARB_RR_EN
          w_owner_d_nxt = ~r_owner_d;  // the master not granted last
`else
          w_owner_d_nxt = 1'b1;        // data beats inst
`endif
          w_state_nxt = w_owner_d_nxt ? GNT_D : GNT_I;
        end else if (bus.data_cyc_in) begin
          w_owner_d_nxt = 1'b1;
          w_state_nxt   = GNT_D;
        end else if (bus.inst_cyc_in) begin
          w_owner_d_nxt = 1'b0;
          w_state_nxt   = GNT_I;
        end
      end
      GNT_I, GNT_D: begin
        if (w_accept && !bus.mem_akn_in)
          w_outst_nxt = r_outst + 2'd1;
        else if (!w_accept && bus.mem_akn_in && (r_outst != 2'd0))
          w_outst_nxt = r_outst - 2'd1;
        if ((r_outst == 2'd0) || bus.mem_akn_in) w_wdog_nxt = '0;
        else if (r_wdog != 8'hFF)                w_wdog_nxt = r_wdog + 8'd1;
        // Release only once every issued request has been acknowledged.
        if (!w_own_cyc && (w_outst_nxt == 2'd0)) w_state_nxt = IDLE;
        else if (w_wdog_nxt == TIMEOUT_V)        w_state_nxt = ABORT;
      end
      ABORT: begin
        w_outst_nxt = '0;
        w_wdog_nxt  = '0;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, counters and owner register; reset drops any transaction silently.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_state   <= IDLE;
      r_outst   <= '0;
      r_wdog    <= '0;
      r_owner_d <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values together.
      r_state   <= w_state_nxt;
      r_outst   <= w_outst_nxt;
      r_wdog    <= w_wdog_nxt;
      r_owner_d <= w_owner_d_nxt;
    end
  end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Self-checking bench for cpu_mem_arbiter (TIMEOUT_CYC = 4). Directed
// scenarios with fixed expectations, then randomized traffic compared every
// cycle against a transaction-level model of the arbitration rules.
module tb_cpu_mem_arbiter;

  localparam int TMO = 4;
`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  cpu_mem_arbiter_if bus ();

  cpu_mem_arbiter #(.TIMEOUT_CYC(TMO)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic clear_inputs();
    bus.inst_cyc_in = 0; bus.inst_stb_in = 0; bus.inst_addr_in = '0;
    bus.data_cyc_in = 0; bus.data_stb_in = 0; bus.data_we_in = 0;
    bus.data_be_in = '0; bus.data_addr_in = '0; bus.data_wdata_in = '0;
    bus.mem_akn_in = 0; bus.mem_stall_in = 0; bus.mem_rdata_in = '0;
  endtask

  task automatic next_cycle();
    @(posedge sys_clk); #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    sys_rst = 0;
    repeat (2) @(posedge sys_clk);
    #1 sys_rst = 1;
  endtask

  // ---------------- model: who owns the port, how many requests are in flight
  int m_owner;  // 0 none, 1 inst, 2 data
  int m_pend;
  int m_wait;
  int m_last;   // 1 inst, 2 data
  bit m_abort;

  function automatic void model_reset();
    m_owner = 0; m_pend = 0; m_wait = 0; m_last = 1; m_abort = 0;
  endfunction

  // Advance the model by one clock using the inputs of the cycle just ended.
  function automatic void model_step();
    bit cyc, stb, acc, akn;
    if (m_abort) begin
      m_abort = 0; m_owner = 0; m_pend = 0; m_wait = 0;
    end else if (m_owner == 0) begin
      if (bus.inst_cyc_in && bus.data_cyc_in) m_owner = RR ? ((m_last == 2) ? 1 : 2) : 2;
      else if (bus.data_cyc_in)               m_owner = 2;
      else if (bus.inst_cyc_in)               m_owner = 1;
      if (m_owner != 0) m_last = m_owner;
    end else begin
      cyc = (m_owner == 2) ? bus.data_cyc_in : bus.inst_cyc_in;
      stb = (m_owner == 2) ? bus.data_stb_in : bus.inst_stb_in;
      acc = cyc && stb && (m_pend < 3) && !bus.mem_stall_in;
      akn = bus.mem_akn_in;
      if (m_pend == 0 || akn) m_wait = 0;
      else if (m_wait < 255)  m_wait++;
      m_pend = m_pend + (acc ? 1 : 0) - ((akn && m_pend + (acc ? 1 : 0) > 0) ? 1 : 0);
      if (!cyc && m_pend == 0) m_owner = 0;
      else if (m_wait == TMO)  m_abort = 1;
    end
  endfunction

  function automatic logic [140:0] model_out();
    logic ia = 0, is = 1, ie = 0, da = 0, ds = 1, de = 0;
    logic [31:0] id = '0, dd = '0, ma = '0, mwd = '0;
    logic mc = 0, ms = 0, mw = 0;
    logic [3:0] mb = '0;
    bit full = (m_pend == 3);
    if (m_abort) begin
      if (m_owner == 2) de = 1; else ie = 1;
    end else if (m_owner == 1) begin
      mc = bus.inst_cyc_in; ms = bus.inst_cyc_in & bus.inst_stb_in & !full;
      mb = 4'hF; ma = bus.inst_addr_in;
      is = bus.mem_stall_in | full; ia = bus.mem_akn_in; id = bus.mem_rdata_in;
    end else if (m_owner == 2) begin
      mc = bus.data_cyc_in; ms = bus.data_cyc_in & bus.data_stb_in & !full;
      mw = bus.data_we_in; mb = bus.data_be_in; ma = bus.data_addr_in; mwd = bus.data_wdata_in;
      ds = bus.mem_stall_in | full; da = bus.mem_akn_in; dd = bus.mem_rdata_in;
    end
    return {ia, is, ie, id, da, ds, de, dd, mc, ms, mw, mb, ma, mwd};
  endfunction

  function automatic logic [140:0] dut_out();
    return {bus.inst_akn_out, bus.inst_stall_out, bus.inst_err_out, bus.inst_data_out,
            bus.data_akn_out, bus.data_stall_out, bus.data_err_out, bus.data_rdata_out,
            bus.mem_cyc_out, bus.mem_stb_out, bus.mem_we_out, bus.mem_be_out,
            bus.mem_addr_out, bus.mem_wdata_out};
  endfunction

  // ---------------- scenarios
  task automatic test_reset();
    clear_inputs();
    sys_rst = 0;
    #3;
    total++; if (bus.inst_stall_out !== 1'b1) begin bad++; $display("FAIL reset_inst_stall got=%b exp=1", bus.inst_stall_out); end
    total++; if (bus.data_stall_out !== 1'b1) begin bad++; $display("FAIL reset_data_stall got=%b exp=1", bus.data_stall_out); end
    total++; if ({bus.mem_cyc_out, bus.mem_stb_out, bus.mem_we_out, bus.mem_be_out, bus.mem_addr_out, bus.mem_wdata_out} !== '0) begin
      bad++; $display("FAIL reset_mem_outputs got=%h exp=0", {bus.mem_cyc_out, bus.mem_stb_out, bus.mem_we_out, bus.mem_be_out, bus.mem_addr_out, bus.mem_wdata_out}); end
    total++; if ({bus.inst_akn_out, bus.inst_err_out, bus.inst_data_out, bus.data_akn_out, bus.data_err_out, bus.data_rdata_out} !== '0) begin
      bad++; $display("FAIL reset_master_outputs got=%h exp=0", {bus.inst_akn_out, bus.inst_err_out, bus.inst_data_out, bus.data_akn_out, bus.data_err_out, bus.data_rdata_out}); end
    do_reset();
  endtask

  task automatic test_single_fetch();
    do_reset();
    bus.inst_cyc_in = 1; bus.inst_stb_in = 1; bus.inst_addr_in = 32'h100;
    @(negedge sys_clk);
    total++; if ({bus.inst_stall_out, bus.mem_stb_out} !== 2'b10) begin bad++; $display("FAIL fetch_idle_stall got=%b exp=10", {bus.inst_stall_out, bus.mem_stb_out}); end
    next_cycle(); @(negedge sys_clk);
    total++; if ({bus.mem_cyc_out, bus.mem_stb_out, bus.mem_we_out, bus.mem_be_out, bus.inst_stall_out} !== 8'b110_1111_0) begin
      bad++; $display("FAIL fetch_forward_ctl got=%b exp=11011110", {bus.mem_cyc_out, bus.mem_stb_out, bus.mem_we_out, bus.mem_be_out, bus.inst_stall_out}); end
    total++; if (bus.mem_addr_out !== 32'h100) begin bad++; $display("FAIL fetch_forward_addr got=%h exp=00000100", bus.mem_addr_out); end
    next_cycle(); bus.inst_stb_in = 0;
    next_cycle(); bus.mem_akn_in = 1; bus.mem_rdata_in = 32'h13;
    @(negedge sys_clk);
    total++; if ({bus.inst_akn_out, bus.data_akn_out} !== 2'b10) begin bad++; $display("FAIL fetch_akn got=%b exp=10", {bus.inst_akn_out, bus.data_akn_out}); end
    total++; if (bus.inst_data_out !== 32'h13) begin bad++; $display("FAIL fetch_data got=%h exp=00000013", bus.inst_data_out); end
    next_cycle(); bus.mem_akn_in = 0; bus.inst_cyc_in = 0;
    next_cycle(); @(negedge sys_clk);
    total++; if ({bus.inst_stall_out, bus.mem_cyc_out} !== 2'b10) begin bad++; $display("FAIL fetch_back_idle got=%b exp=10", {bus.inst_stall_out, bus.mem_cyc_out}); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    bus.inst_cyc_in = 1; bus.inst_stb_in = 1; bus.inst_addr_in = 32'h300;
    bus.data_cyc_in = 1; bus.data_stb_in = 1; bus.data_we_in = 1; bus.data_be_in = 4'b0011;
    bus.data_addr_in = 32'h2000; bus.data_wdata_in = 32'hDEADBEEF;
    next_cycle(); @(negedge sys_clk);
    total++; if ({bus.mem_we_out, bus.mem_be_out, bus.mem_stb_out, bus.inst_stall_out, bus.data_stall_out} !== 8'b1_0011_1_1_0) begin
      bad++; $display("FAIL simul_first_ctl got=%b exp=10011110", {bus.mem_we_out, bus.mem_be_out, bus.mem_stb_out, bus.inst_stall_out, bus.data_stall_out}); end
    total++; if ({bus.mem_addr_out, bus.mem_wdata_out} !== {32'h2000, 32'hDEADBEEF}) begin
      bad++; $display("FAIL simul_first_addr_data got=%h exp=00002000deadbeef", {bus.mem_addr_out, bus.mem_wdata_out}); end
    next_cycle(); bus.data_stb_in = 0; bus.mem_akn_in = 1;
    @(negedge sys_clk);
    total++; if ({bus.data_akn_out, bus.inst_akn_out} !== 2'b10) begin bad++; $display("FAIL simul_akn_route got=%b exp=10", {bus.data_akn_out, bus.inst_akn_out}); end
    next_cycle(); bus.mem_akn_in = 0; bus.data_cyc_in = 0; bus.inst_cyc_in = 0; bus.inst_stb_in = 0;
    next_cycle(); bus.data_cyc_in = 1; bus.data_stb_in = 1; bus.inst_cyc_in = 1; bus.inst_stb_in = 1;
    next_cycle(); @(negedge sys_clk);
    if (RR) begin
      total++; if ({bus.mem_addr_out, bus.mem_we_out} !== {32'h300, 1'b0}) begin bad++; $display("FAIL simul_second_rr got=%h exp=%h", {bus.mem_addr_out, bus.mem_we_out}, {32'h300, 1'b0}); end
    end else begin
      total++; if ({bus.mem_addr_out, bus.mem_we_out} !== {32'h2000, 1'b1}) begin bad++; $display("FAIL simul_second_fixed got=%h exp=%h", {bus.mem_addr_out, bus.mem_we_out}, {32'h2000, 1'b1}); end
    end
  endtask

  task automatic test_pipeline();
    do_reset();
    bus.inst_cyc_in = 1; bus.inst_stb_in = 1; bus.inst_addr_in = 32'h400;
    repeat (3) next_cycle();  // grant, first accept, second accept
    @(negedge sys_clk);
    total++; if ({bus.inst_stall_out, bus.mem_stb_out} !== 2'b01) begin bad++; $display("FAIL pipe_third_accept got=%b exp=01", {bus.inst_stall_out, bus.mem_stb_out}); end
    next_cycle(); @(negedge sys_clk);
    total++; if ({bus.inst_stall_out, bus.mem_stb_out, bus.mem_cyc_out} !== 3'b101) begin bad++; $display("FAIL pipe_fourth_stalled got=%b exp=101", {bus.inst_stall_out, bus.mem_stb_out, bus.mem_cyc_out}); end
    next_cycle(); bus.mem_akn_in = 1;
    @(negedge sys_clk);
    total++; if ({bus.inst_stall_out, bus.mem_stb_out, bus.inst_akn_out} !== 3'b101) begin bad++; $display("FAIL pipe_akn_cycle got=%b exp=101", {bus.inst_stall_out, bus.mem_stb_out, bus.inst_akn_out}); end
    next_cycle(); bus.mem_akn_in = 0;
    @(negedge sys_clk);
    total++; if ({bus.inst_stall_out, bus.mem_stb_out} !== 2'b01) begin bad++; $display("FAIL pipe_resume got=%b exp=01", {bus.inst_stall_out, bus.mem_stb_out}); end
  endtask

  task automatic test_timeout();
    do_reset();
    bus.data_cyc_in = 1; bus.data_stb_in = 1; bus.data_addr_in = 32'h500; bus.data_be_in = 4'hF;
    next_cycle(); @(negedge sys_clk);
    total++; if (bus.mem_stb_out !== 1'b1) begin bad++; $display("FAIL tmo_accept got=%b exp=1", bus.mem_stb_out); end
    for (int i = 1; i <= 4; i++) begin
      next_cycle(); bus.data_stb_in = 0;
      @(negedge sys_clk);
      total++; if ({bus.data_err_out, bus.mem_cyc_out} !== 2'b01) begin bad++; $display("FAIL tmo_wait_%0d got=%b exp=01", i, {bus.data_err_out, bus.mem_cyc_out}); end
    end
    next_cycle(); bus.mem_akn_in = 1;
    @(negedge sys_clk);
    total++; if ({bus.data_err_out, bus.inst_err_out, bus.data_akn_out, bus.mem_cyc_out, bus.mem_stb_out, bus.data_stall_out} !== 6'b100001) begin
      bad++; $display("FAIL tmo_abort got=%b exp=100001", {bus.data_err_out, bus.inst_err_out, bus.data_akn_out, bus.mem_cyc_out, bus.mem_stb_out, bus.data_stall_out}); end
    next_cycle(); bus.mem_akn_in = 0;
    @(negedge sys_clk);
    total++; if ({bus.data_err_out, bus.mem_cyc_out, bus.data_stall_out} !== 3'b001) begin bad++; $display("FAIL tmo_idle got=%b exp=001", {bus.data_err_out, bus.mem_cyc_out, bus.data_stall_out}); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.inst_cyc_in = 1; bus.inst_stb_in = 1; bus.inst_addr_in = 32'h600;
    repeat (3) next_cycle();  // grant, two accepts -> two outstanding
    bus.inst_stb_in = 0;
    #2 sys_rst = 0;
    #1;
    total++; if ({bus.mem_cyc_out, bus.inst_stall_out, bus.data_stall_out, bus.inst_err_out} !== 4'b0110) begin
      bad++; $display("FAIL rstmid_immediate got=%b exp=0110", {bus.mem_cyc_out, bus.inst_stall_out, bus.data_stall_out, bus.inst_err_out}); end
    next_cycle(); @(negedge sys_clk);
    total++; if (bus.inst_err_out !== 1'b0) begin bad++; $display("FAIL rstmid_no_err got=%b exp=0", bus.inst_err_out); end
    next_cycle(); sys_rst = 1; bus.inst_stb_in = 1; bus.inst_addr_in = 32'h40;
    next_cycle(); @(negedge sys_clk);
    total++; if ({bus.mem_stb_out, bus.mem_addr_out} !== {1'b1, 32'h40}) begin bad++; $display("FAIL rstmid_refetch got=%h exp=%h", {bus.mem_stb_out, bus.mem_addr_out}, {1'b1, 32'h40}); end
    next_cycle(); bus.inst_stb_in = 0; bus.mem_akn_in = 1; bus.mem_rdata_in = 32'hCAFEF00D;
    @(negedge sys_clk);
    total++; if ({bus.inst_akn_out, bus.inst_data_out} !== {1'b1, 32'hCAFEF00D}) begin bad++; $display("FAIL rstmid_refetch_akn got=%h exp=%h", {bus.inst_akn_out, bus.inst_data_out}, {1'b1, 32'hCAFEF00D}); end
  endtask

  task automatic test_early_drop();
    do_reset();
    bus.inst_cyc_in = 1; bus.inst_stb_in = 1; bus.inst_addr_in = 32'h700;
    next_cycle();
    bus.data_cyc_in = 1; bus.data_stb_in = 1; bus.data_we_in = 1; bus.data_be_in = 4'h1; bus.data_addr_in = 32'h800;
    @(negedge sys_clk);
    total++; if ({bus.mem_addr_out, bus.mem_we_out, bus.data_stall_out} !== {32'h700, 2'b01}) begin
      bad++; $display("FAIL drop_nonowner_blocked got=%h exp=%h", {bus.mem_addr_out, bus.mem_we_out, bus.data_stall_out}, {32'h700, 2'b01}); end
    next_cycle(); bus.inst_cyc_in = 0; bus.inst_stb_in = 0;
    @(negedge sys_clk);
    total++; if ({bus.mem_stb_out, bus.data_stall_out, bus.data_akn_out} !== 3'b010) begin bad++; $display("FAIL drop_hold got=%b exp=010", {bus.mem_stb_out, bus.data_stall_out, bus.data_akn_out}); end
    next_cycle(); bus.mem_akn_in = 1; bus.mem_rdata_in = 32'h77;
    @(negedge sys_clk);
    total++; if ({bus.inst_akn_out, bus.data_akn_out, bus.mem_stb_out, bus.data_rdata_out} !== {3'b100, 32'h0}) begin
      bad++; $display("FAIL drop_akn_owner got=%h exp=%h", {bus.inst_akn_out, bus.data_akn_out, bus.mem_stb_out, bus.data_rdata_out}, {3'b100, 32'h0}); end
    next_cycle(); bus.mem_akn_in = 0;
    @(negedge sys_clk);
    total++; if ({bus.mem_cyc_out, bus.data_stall_out} !== 2'b01) begin bad++; $display("FAIL drop_idle got=%b exp=01", {bus.mem_cyc_out, bus.data_stall_out}); end
    next_cycle(); @(negedge sys_clk);
    total++; if ({bus.mem_cyc_out, bus.mem_we_out, bus.data_stall_out, bus.mem_addr_out} !== {3'b110, 32'h800}) begin
      bad++; $display("FAIL drop_other_granted got=%h exp=%h", {bus.mem_cyc_out, bus.mem_we_out, bus.data_stall_out, bus.mem_addr_out}, {3'b110, 32'h800}); end
  endtask

  task automatic test_random();
    logic [140:0] got, exp;
    int shown = 0;
    do_reset();
    model_reset();
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 7) == 0) bus.inst_cyc_in = ~bus.inst_cyc_in;
      if ($urandom_range(0, 7) == 0) bus.data_cyc_in = ~bus.data_cyc_in;
      bus.inst_stb_in   = ($urandom_range(0, 3) != 0);
      bus.data_stb_in   = ($urandom_range(0, 3) != 0);
      bus.inst_addr_in  = $urandom;
      bus.data_addr_in  = $urandom;
      bus.data_wdata_in = $urandom;
      bus.data_we_in    = $urandom_range(0, 1) == 1;
      bus.data_be_in    = 4'($urandom_range(0, 15));
      bus.mem_akn_in    = ($urandom_range(0, 3) == 0);
      bus.mem_stall_in  = ($urandom_range(0, 4) == 0);
      bus.mem_rdata_in  = $urandom;
      @(negedge sys_clk);
      got = dut_out();
      exp = model_out();
      total++;
      if (got !== exp) begin
        bad++;
        if (shown < 10) begin
          shown++;
          $display("FAIL random_cycle_%0d got=%h exp=%h", n, got, exp);
        end
      end
      @(posedge sys_clk);
      model_step();
      #1;
    end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_pipeline();
    test_timeout();
    test_reset_mid();
    test_early_drop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_mem_arbiter.md
CPU_MEM_ARBITER -- requirements
Module: cpu_mem_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYC, 255, cycles a memory request may wait for akn before abort; legal range 2..255.
REQ-002 sys_clk  in  1  single clock; all logic rising-edge.
REQ-003 sys_rst  in  1  asynchronous, active-low reset.
REQ-004 inst_cyc_in, inst_stb_in  in  1 each  instruction master bus cycle / strobe.
REQ-005 inst_addr_in  in  32  instruction fetch address.
REQ-006 inst_akn_out, inst_stall_out, inst_err_out  out  1 each  acknowledge / stall / abort to fetch master.
REQ-007 inst_data_out  out  32  fetched instruction word.
REQ-008 data_cyc_in, data_stb_in, data_we_in  in  1 each  data master cycle / strobe / write-enable.
REQ-009 data_be_in  in  4  byte enables; data_addr_in, data_wdata_in  in  32 each  address / write data.
REQ-010 data_akn_out, data_stall_out, data_err_out  out  1 each; data_rdata_out  out  32  load data.
REQ-011 mem_cyc_out, mem_stb_out, mem_we_out  out  1 each; mem_be_out  out  4; mem_addr_out, mem_wdata_out  out  32 each  shared memory port.
REQ-012 mem_akn_in, mem_stall_in  in  1 each; mem_rdata_in  in  32  memory response.

Function
REQ-013 FSM states IDLE, GNT_I, GNT_D, ABORT; state, grant and counters are registered.
REQ-014 IDLE: no grant; both stalls = 1, all mem_* outputs = 0; a cyc request moves FSM to GNT_I/GNT_D next cycle.
REQ-015 Both cyc_in high in IDLE: priority per REQ-031/032.
REQ-016 GNT_x: mem_cyc/stb/we/be/addr/wdata driven combinationally from the owner (inst: we=0, be=4'hF, wdata=0); owner stall = mem_stall_in OR (outstanding==3).
REQ-017 Non-owner: stall=1, akn=0, err=0; its request is never forwarded.
REQ-018 mem_akn_in and mem_rdata_in routed to the owner only; non-owner data outputs = 0.
REQ-019 Outstanding counter (2-bit): +1 on accepted strobe (stb & !stall), -1 on mem_akn_in; both in the same cycle leaves it unchanged.
REQ-020 At outstanding==3 the owner is stalled and mem_stb_out is forced to 0.
REQ-021 Grant release: owner cyc_in low AND outstanding==0 -> IDLE next cycle; a cyc drop with outstanding>0 holds the grant with mem_stb_out=0 until all akns return.
REQ-022 Watchdog: an 8-bit counter runs while outstanding>0 and no akn arrives; it clears on any akn or when outstanding==0.
REQ-023 Watchdog reaching TIMEOUT_CYC -> ABORT next cycle.
REQ-024 ABORT (exactly 1 cycle): mem_cyc_out=0, mem_stb_out=0, owner err_out=1, outstanding and watchdog cleared, then IDLE.
REQ-025 An akn arriving in the ABORT cycle is discarded; no akn_out is driven.
REQ-026 Zero added latency: akn_out is asserted in the same cycle as mem_akn_in.
REQ-027 Grant changes only from IDLE; no master switch occurs mid-cycle.

Reset
REQ-028 sys_rst low -> state IDLE, outstanding=0, watchdog=0, last-grant=INST; takes effect immediately, without waiting for a clock edge.
REQ-029 Reset values: all mem_* outputs 0; akn/err/data outputs 0; both stall outputs 1.
REQ-030 Reset asserted mid-transaction drops the transaction silently; no err pulse is generated.

Configuration
REQ-031 ARB_RR_EN defined: round-robin; on a simultaneous request, grant the master not granted last (the last-grant register updates on every grant).
REQ-032 ARB_RR_EN undefined: fixed priority, data beats inst on a simultaneous request; the last-grant register is absent.

Verification
REQ-033 Single fetch: inst_cyc/stb=1, addr=0x100; mem_akn_in with rdata=0x00000013 two cycles later -> inst_akn_out=1, inst_data_out=0x00000013 in the same cycle; IDLE after cyc drops.
REQ-034 Simultaneous request from IDLE: store be=4'b0011, addr=0x2000, wdata=0xDEADBEEF plus a fetch -> mem_we_out=1, mem_be_out=4'b0011 forwarded first; with ARB_RR_EN, a second simultaneous request is granted to inst.
REQ-035 Pipelined fetch: 4 strobes issued with no akn -> 4th strobe stalled (inst_stall_out=1, mem_stb_out=0) until the first akn returns.
REQ-036 Timeout: TIMEOUT_CYC=4, one accepted data strobe, mem_akn_in held 0 -> ABORT in cycle 5 after acceptance, data_err_out=1 for one cycle, mem_cyc_out=0, then IDLE.
REQ-037 Reset: sys_rst driven low while outstanding=2 -> immediately mem_cyc_out=0, both stalls=1; after release, a new fetch completes normally.
REQ-038 Early cyc drop: owner drops cyc with outstanding=1 -> grant held, mem_stb_out=0 until akn, IDLE the next cycle; the other master's pending request is then granted.
